vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 SHALL have port iCLK, input, 1, pixel clock (PCLK, 25 MHz); the only clock.
REQ-011 SHALL have port iRST, input, 1, synchronous active-high reset.
REQ-012 SHALL have port iEN, input, 1, timing run request.
REQ-013 SHALL have port oHSYNC, output, 1, horizontal sync.
REQ-014 SHALL have port oVSYNC, output, 1, vertical sync.
REQ-015 SHALL have port oDE, output, 1, active-video data enable.
REQ-016 SHALL have port oX, output, 10, pixel column within the line.
REQ-017 SHALL have port oY, output, 10, line number within the frame.
REQ-018 SHALL have port oLINE_START, output, 1, one-cycle pulse at column 0 of every line.
REQ-019 SHALL have port oFRAME_START, output, 1, one-cycle pulse at column 0 of line 0.
REQ-020 SHALL have port oBUSY, output, 1, high while in state RUN.

Function
REQ-021 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-022 SHALL implement FSM states IDLE and RUN, plus a registered stop-pending flag.
REQ-023 SHALL move from IDLE to RUN on the edge where iEN is sampled high, with hcnt = vcnt = 0 on the first RUN cycle.
REQ-024 SHALL, in RUN, increment hcnt each cycle; at hcnt = H_TOTAL-1, wrap hcnt to 0 and increment vcnt; at vcnt = V_TOTAL-1 with hcnt = H_TOTAL-1, wrap vcnt to 0.
REQ-025 SHALL set stop-pending when iEN is low in RUN, and return to IDLE only at the end of the frame (hcnt = H_TOTAL-1, vcnt = V_TOTAL-1) if stop-pending is still set.
REQ-026 SHALL clear stop-pending if iEN returns high before the end of the frame, continuing the next frame seamlessly.
REQ-027 SHALL hold hcnt and vcnt at 0 in IDLE.
REQ-028 SHALL register all outputs from the current counter state (1-cycle latency), with all outputs mutually aligned.
REQ-029 SHALL assert oDE when in RUN, hcnt < H_ACTIVE and vcnt < V_ACTIVE; oX/oY SHALL equal hcnt/vcnt when oDE is high and SHALL be 0 otherwise.
REQ-030 SHALL drive oHSYNC to SYNC_POL for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751), and to ~SYNC_POL otherwise.
REQ-031 SHALL drive oVSYNC to SYNC_POL over the whole lines V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), and to ~SYNC_POL otherwise.
REQ-032 SHALL hold sync outputs at ~SYNC_POL and oDE, oLINE_START and oFRAME_START at 0 while in IDLE.
REQ-033 SHALL size counter compares so that parameters up to 1023 per dimension total are handled without overflow.

Reset
REQ-034 SHALL, on iRST high, enter IDLE, clear stop-pending and zero hcnt/vcnt on the next edge, regardless of frame position.
REQ-035 SHALL reset oHSYNC/oVSYNC to ~SYNC_POL and all other outputs to 0.
REQ-036 SHALL give iRST priority over iEN when both are high in the same cycle.

Configuration
REQ-037 SHALL, with macro VGA_TIMING_GEN_FRAME_CNT_EN defined, add output oFRAME_CNT[15:0], reset 0, incremented in the same cycle oFRAME_START asserts, wrapping from 0xFFFF to 0x0000.
REQ-038 SHALL, without VGA_TIMING_GEN_FRAME_CNT_EN, omit the oFRAME_CNT port and its counter entirely.

Verification
REQ-039 SHALL cover reset then iEN=1 at cycle 0 -> oFRAME_START, oLINE_START and oDE first high at cycle 2 with oX=0, oY=0; oBUSY high at cycle 1.
REQ-040 SHALL cover the first line in RUN -> oDE high for 640 cycles, oHSYNC low for exactly 96 cycles starting at column 656, and oLINE_START period 800 cycles.
REQ-041 SHALL cover free running -> oFRAME_START period 420000 cycles and oVSYNC low for 1600 cycles starting at line 490, column 0.
REQ-042 SHALL cover iEN dropped at line 100 -> frame completes through line 524, then oBUSY=0 with outputs idle; iEN re-raised at line 300 of another frame -> no gap between frames.
REQ-043 SHALL cover iRST pulsed at line 200, column 400 -> next-cycle counters at 0, outputs at reset values, and restart from frame start when iEN is high.
REQ-044 SHALL cover a build with VGA_TIMING_GEN_FRAME_CNT_EN, oFRAME_CNT preloaded via force to 0xFFFF -> reads 0x0000 after the next oFRAME_START.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Bundle between the VGA timing generator and its pixel pipeline consumer; optional oFRAME_CNT via VGA_TIMING_GEN_FRAME_CNT_EN.
// Latency: none (wires only).
// Backpressure: none; the timing stream is free running and cannot be stalled.
interface vga_timing_gen_if;
  logic       iEN;
  logic       oHSYNC;
  logic       oVSYNC;
  logic       oDE;
  logic [9:0] oX;
  logic [9:0] oY;
  logic       oLINE_START;
  logic       oFRAME_START;
  logic       oBUSY;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] oFRAME_CNT;
`endif

  // Generator side: takes the run request, drives timing.
  modport master (
    input  iEN,
    output oHSYNC, oVSYNC, oDE, oX, oY, oLINE_START, oFRAME_START, oBUSY
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    , output oFRAME_CNT
`endif
  );

  // Consumer side: requests running, observes timing.
  modport slave (
    output iEN,
    input  oHSYNC, oVSYNC, oDE, oX, oY, oLINE_START, oFRAME_START, oBUSY
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    , input oFRAME_CNT
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA sync/DE/coordinate generator with IDLE/RUN control; VGA_TIMING_GEN_FRAME_CNT_EN adds a 16-bit frame counter.
// Latency: outputs are registered one cycle behind the counters; oBUSY decodes the state register directly.
// Backpressure: none; dropping iEN only stops the timing at the end of the current frame.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic iCLK,
  input  logic iRST,
  vga_timing_gen_if.master vga
);

  // 11-bit constants so totals up to 1023 compare against the 10-bit counters without wrap.
  localparam logic [10:0] H_ACT_C   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS_C    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE_C    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_TOTAL_C = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_ACT_C   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS_C    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE_C    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_TOTAL_C = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic        SYNC_ON   = (SYNC_POL != 0);
  localparam logic        SYNC_OFF  = ~SYNC_ON;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] hcnt, hcnt_nxt;
  logic [9:0] vcnt, vcnt_nxt;
  logic       stop_pend, stop_pend_nxt;

  logic       run;
  logic       h_last, v_last;
  logic       de_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;
  logic [9:0] x_nxt, y_nxt;

  logic       hsync_q, vsync_q, de_q, ls_q, fs_q;
  logic [9:0] x_q, y_q;

  assign run    = (state == RUN);
  assign h_last = ({1'b0, hcnt} == (H_TOTAL_C - 11'd1));
  assign v_last = ({1'b0, vcnt} == (V_TOTAL_C - 11'd1));

  // State, counters and stop-pending flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  // Next state: raster scan in RUN; a stop request is only honoured on the last pixel of a frame.
  always_comb begin
    state_nxt     = state;
    hcnt_nxt      = hcnt;
    vcnt_nxt      = vcnt;
    stop_pend_nxt = stop_pend;
    case (state)
      IDLE: begin
        hcnt_nxt      = '0;
        vcnt_nxt      = '0;
        stop_pend_nxt = 1'b0;
        if (vga.iEN) state_nxt = RUN;
      end
      RUN: begin
        // Tracks iEN each cycle, so a re-raise before frame end cancels the stop.
        stop_pend_nxt = ~vga.iEN;
        if (h_last) begin
          hcnt_nxt = '0;
          if (v_last) begin
            vcnt_nxt = '0;
            if (stop_pend) begin
              state_nxt     = IDLE;
              stop_pend_nxt = 1'b0;
            end
          end else begin
            vcnt_nxt = vcnt + 10'd1;
          end
        end else begin
          hcnt_nxt = hcnt + 10'd1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        hcnt_nxt      = '0;
        vcnt_nxt      = '0;
        stop_pend_nxt = 1'b0;
      end
    endcase
  end

  // Output decode from the current counter position; everything is gated by RUN so IDLE looks blank.
  always_comb begin
    de_nxt = run && ({1'b0, hcnt} < H_ACT_C) && ({1'b0, vcnt} < V_ACT_C);
    x_nxt  = de_nxt ? hcnt : 10'd0;
    y_nxt  = de_nxt ? vcnt : 10'd0;
    hs_nxt = SYNC_OFF;
    vs_nxt = SYNC_OFF;
    if (run && ({1'b0, hcnt} >= H_SS_C) && ({1'b0, hcnt} < H_SE_C)) hs_nxt = SYNC_ON;
    if (run && ({1'b0, vcnt} >= V_SS_C) && ({1'b0, vcnt} < V_SE_C)) vs_nxt = SYNC_ON;
    ls_nxt = run && (hcnt == 10'd0);
    fs_nxt = run && (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  // Output registers, all aligned one cycle behind the counters.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hs_nxt;
      vsync_q <= vs_nxt;
      de_q    <= de_nxt;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      ls_q    <= ls_nxt;
      fs_q    <= fs_nxt;
    end
  end

  assign vga.oHSYNC       = hsync_q;
  assign vga.oVSYNC       = vsync_q;
  assign vga.oDE          = de_q;
  assign vga.oX           = x_q;
  assign vga.oY           = y_q;
  assign vga.oLINE_START  = ls_q;
  assign vga.oFRAME_START = fs_q;
  assign vga.oBUSY        = run;

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  // Frame counter steps on the same edge that raises oFRAME_START, wrapping naturally at 16 bits.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      frame_cnt <= '0;
    end else if (fs_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign vga.oFRAME_CNT = frame_cnt;
`endif

endmodule
